// File: rtl/flexsoc_uart_pkg.sv
// flexsoc_uart_pkg: shared types, constants and helpers for the flexsoc UART blocks
package flexsoc_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    function automatic int calc_divisor(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   hclk,
    input  logic                   RESET,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // storage array, written at the tail
    always_ff @(posedge hclk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge hclk) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_wr);
            rd_ptr <= rd_ptr + AW'(do_rd);
            level  <= level + LW'(do_wr) - LW'(do_rd);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter with CTS flow control at frame boundaries
module uart_tx_fifo
    import flexsoc_uart_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DEPTH     = 16,
    parameter int STOP_BITS = 1
) (
    input  logic                      hclk,
    input  logic                      RESET,
    input  logic [UART_DATA_BITS-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      cts_n,
    output logic                      UART_TX,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD);
    localparam int CW      = $clog2(DIVISOR);
    localparam int LW      = $clog2(DEPTH) + 1;

    if (DIVISOR < 4) begin : g_div_chk
        $error("uart_tx_fifo: DIVISOR must be at least 4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t            state;
    logic [CW-1:0]             baud_cnt;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] fifo_data;
    logic                      empty;
    logic                      full;
    logic                      tick;
    logic                      wr;
    logic                      pop;
    logic [LW-1:0]             lvl_nxt;

    assign tick    = baud_cnt == CW'(DIVISOR - 1);
    assign wr      = in_valid & in_ready & ~full;
    assign pop     = ~empty & ~cts_n & ((state == IDLE) |
                     ((state == STOP) & tick & (bit_cnt == 3'(STOP_BITS - 1))));
    assign lvl_nxt = fifo_level + LW'(wr) - LW'(pop);
    assign busy    = (state != IDLE) | (fifo_level != '0);

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .hclk    (hclk),
        .RESET   (RESET),
        .wr_en   (wr),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    // ready tracks next-cycle occupancy so it drops on the edge the FIFO fills
    always_ff @(posedge hclk) in_ready <= !RESET && lvl_nxt != LW'(DEPTH);

    // frame sequencer: baud counter, bit counter, shift register and line flop
    always_ff @(posedge hclk) begin
        if (RESET) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            UART_TX  <= 1'b1;
        end else begin
            baud_cnt <= (state == IDLE || tick) ? '0 : baud_cnt + 1'b1;
            case (state)
                IDLE: if (pop) begin
                    shift   <= fifo_data;
                    state   <= START;
                    UART_TX <= 1'b0;
                end
                START: if (tick) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    UART_TX <= shift[0];
                end
                DATA: if (tick) begin
                    if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        UART_TX <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shift   <= shift >> 1;
                        UART_TX <= shift[1];
                    end
                end
                STOP: if (tick) begin
                    if (bit_cnt == 3'(STOP_BITS - 1)) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shift   <= fifo_data;
                            state   <= START;
                            UART_TX <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench decoding the serial line of uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int CLK_HZ = 800;
    localparam int BAUD   = 100;
    localparam int D      = 8;
    localparam int DEPTH  = 4;

    logic       hclk = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data2 = '0;
    logic       in_valid2 = 1'b0;
    logic       cts_n = 1'b0;
    logic       in_ready, in_ready2, tx1, tx2, busy, busy2;
    logic [2:0] fifo_level, fifo_level2;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] sb[$];
    int         starts[$];
    logic       sel = 1'b0;
    int         mon_sb = 1;
    logic       tx_mon, busy_mon;

    assign tx_mon   = sel ? tx2 : tx1;
    assign busy_mon = sel ? busy2 : busy;

    always #5 hclk = ~hclk;
    always @(posedge hclk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .STOP_BITS(1)) dut (
        .hclk(hclk), .RESET(RESET), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .cts_n(cts_n), .UART_TX(tx1), .busy(busy),
        .fifo_level(fifo_level)
    );

    uart_tx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
        .hclk(hclk), .RESET(RESET), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .cts_n(cts_n), .UART_TX(tx2), .busy(busy2),
        .fifo_level(fifo_level2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write1(input logic [7:0] b, output int k);
        in_data  = b;
        in_valid = 1'b1;
        check("wr_ready", in_ready, 1);
        if (in_ready) sb.push_back(b);
        @(negedge hclk);
        in_valid = 1'b0;
        k = cyc;
    endtask

    task automatic wait_idle(input int lim, output int t);
        int i = 0;
        while (busy_mon && i < lim) begin
            @(negedge hclk);
            i++;
        end
        check("idle_timeout", busy_mon, 0);
        t = cyc;
    endtask

    logic [10:0] ms;
    bit          m_abort;

    // line monitor: decodes each frame mid-bit and compares against the scoreboard
    initial begin
        forever begin
            @(negedge hclk);
            if (!RESET && tx_mon === 1'b0) begin
                starts.push_back(cyc);
                m_abort = 1'b0;
                ms = '0;
                for (int i = 0; i < 9 + mon_sb; i++) begin
                    repeat (i == 0 ? D / 2 : D) begin
                        @(negedge hclk);
                        if (RESET) m_abort = 1'b1;
                    end
                    if (m_abort) break;
                    ms[i] = tx_mon;
                end
                if (!m_abort) begin
                    repeat (D / 2 - 1) @(negedge hclk);
                    check("start_bit", ms[0], 0);
                    check("stop_bits", ms >> 9, mon_sb == 2 ? 3 : 1);
                    check("rx_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) check("rx_byte", ms[8:1], sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         k, t, c0, n, lv[3];
        bit         saw_full;
        logic [7:0] bytes[3];

        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check("rst_tx", tx1, 1);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        RESET = 1'b0;
        @(negedge hclk);
        check("ready_after_rst", in_ready, 1);

        starts.delete();
        write1(8'hA5, k);
        wait_idle(200, t);
        check("a5_busy_low", t, k + 81);
        check("a5_frames", starts.size(), 1);
        if (starts.size() == 1) check("a5_start", starts[0], k + 1);

        starts.delete();
        bytes = '{8'h00, 8'hFF, 8'h55};
        for (int i = 0; i < 3; i++) begin
            in_data  = bytes[i];
            in_valid = 1'b1;
            if (in_ready) sb.push_back(bytes[i]);
            @(negedge hclk);
            lv[i] = fifo_level;
            if (i == 0) k = cyc;
        end
        in_valid = 1'b0;
        check("b2b_lvl0", lv[0], 1);
        check("b2b_lvl1", lv[1], 1);
        check("b2b_lvl2", lv[2], 2);
        repeat (78) @(negedge hclk);
        check("b2b_lvl_k80", fifo_level, 2);
        @(negedge hclk);
        check("b2b_lvl_k81", fifo_level, 1);
        repeat (80) @(negedge hclk);
        check("b2b_lvl_k161", fifo_level, 0);
        wait_idle(300, t);
        check("b2b_busy_low", t, k + 241);
        check("b2b_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            check("b2b_start0", starts[0], k + 1);
            check("b2b_start1", starts[1], k + 81);
            check("b2b_start2", starts[2], k + 161);
        end

        starts.delete();
        n = 0;
        saw_full = 1'b0;
        for (int i = 0; i < 1000 && n < 6; i++) begin
            in_data  = 8'h10 + 8'(n);
            in_valid = 1'b1;
            check("bp_ready_vs_level", in_ready, fifo_level != 3'd4);
            if (fifo_level == 3'd4) saw_full = 1'b1;
            if (in_ready) begin
                sb.push_back(in_data);
                n++;
            end
            @(negedge hclk);
        end
        in_valid = 1'b0;
        check("bp_saw_full", saw_full, 1);
        check("bp_accepted", n, 6);
        wait_idle(700, t);
        check("bp_frames", starts.size(), 6);
        check("bp_sb_empty", sb.size(), 0);

        starts.delete();
        write1(8'h3C, k);
        write1(8'h3D, t);
        repeat (3) @(negedge hclk);
        cts_n = 1'b1;
        repeat (k + 100 - cyc) @(negedge hclk);
        check("fc_line_idle", tx1, 1);
        check("fc_level", fifo_level, 1);
        check("fc_busy", busy, 1);
        check("fc_frames_paused", starts.size(), 1);
        c0 = cyc;
        cts_n = 1'b0;
        @(negedge hclk);
        check("fc_resume_tx", tx1, 0);
        wait_idle(200, t);
        check("fc_frames", starts.size(), 2);
        if (starts.size() == 2) check("fc_resume_start", starts[1], c0 + 1);

        starts.delete();
        write1(8'h91, k);
        write1(8'h77, t);
        repeat (k + 36 - cyc) @(negedge hclk);
        check("rst_mid_bit3", tx1, 0);
        RESET = 1'b1;
        @(negedge hclk);
        check("rst_mid_tx", tx1, 1);
        check("rst_mid_level", fifo_level, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", in_ready, 0);
        @(negedge hclk);
        RESET = 1'b0;
        sb.delete();
        @(negedge hclk);
        starts.delete();
        write1(8'h81, k);
        wait_idle(200, t);
        check("post_rst_busy_low", t, k + 81);
        check("post_rst_frames", starts.size(), 1);

        sel = 1'b1;
        mon_sb = 2;
        starts.delete();
        in_data2  = 8'hC3;
        in_valid2 = 1'b1;
        check("sb2_ready", in_ready2, 1);
        if (in_ready2) sb.push_back(8'hC3);
        @(negedge hclk);
        in_valid2 = 1'b0;
        k = cyc;
        repeat (87) @(negedge hclk);
        check("sb2_last_stop_tx", tx2, 1);
        check("sb2_busy_k88", busy2, 1);
        wait_idle(200, t);
        check("sb2_busy_low", t, k + 89);
        check("sb2_frames", starts.size(), 1);
        if (starts.size() == 1) check("sb2_start", starts[0], k + 1);

        repeat (5) @(negedge hclk);
        check("final_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Host-bound UART transmitter for the flexsoc FPGA tops. Drives the board UART_TX pin back to the host PC.
- Accepts bytes over a valid/ready stream in the hclk domain and buffers them in a small FIFO.
- Serialises each byte as 8N1 (optionally 2 stop bits) at a fixed baud rate derived from the hclk frequency.
- Optional hardware flow control pauses transmission at frame boundaries.

Parameters:
- CLK_HZ, 50000000, hclk frequency in Hz.
- BAUD, 115200, line rate in bits/s. Local DIVISOR = (CLK_HZ + BAUD/2) / BAUD, rounded, so 434 at the defaults. Elaboration error if DIVISOR < 4.
- DEPTH, 16, FIFO entries. Must be a power of 2, ≥ 2.
- STOP_BITS, 1, number of stop bits. Legal values are 1 and 2.

Ports:
- hclk  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a byte. Equals !full.
- cts_n  in  1  clear-to-send, active-low. Tie 0 if unused. Assumed already synchronised to hclk.
- UART_TX  out  1  serial line. Idles high.
- busy  out  1  a frame is in progress, or the FIFO is non-empty.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset: RESET is synchronous and active-high; clock is hclk.
  - While RESET is high at a hclk edge: UART_TX=1, in_ready=0, busy=0, fifo_level=0.
  - FIFO is flushed, bit counter=0, baud counter=0, FSM=IDLE.
  - in_ready goes high on the first edge after RESET deasserts.
- Reset mid-frame: aborts the frame immediately. Line returns high; partial bits are discarded.
- Write side:
  - A byte is written when in_valid & in_ready are both high at a hclk edge.
  - in_ready is registered and equals !full. It drops in the same cycle fifo_level reaches DEPTH.
  - Write and pop on the same edge: occupancy is unchanged.
  - Write while full never happens, because in_ready=0 when full.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: UART_TX=1. If FIFO is non-empty and cts_n=0, at the next edge: pop the head into a shift register, enter START, drive UART_TX=0, baud counter=0.
  - START: hold 0 for DIVISOR cycles, then enter DATA with bit index 0.
  - DATA: drive shift[0] (LSB first) for DIVISOR cycles per bit, shifting right after each bit. After bit 7 enter STOP.
  - STOP: hold 1 for STOP_BITS*DIVISOR cycles. On the final cycle:
    - if FIFO is non-empty and cts_n=0, pop and go straight to START, so there is no idle gap between frames;
    - otherwise go to IDLE.
- UART_TX is driven from a flop, so it is glitch-free.
- Latency: a byte written at edge k into an empty FIFO with the FSM in IDLE pops at edge k+1. UART_TX falls after edge k+1.
- Frame length: exactly (9+STOP_BITS)*DIVISOR cycles.
- Baud counter: counts 0..DIVISOR-1 and wraps. A bit boundary occurs on the wrap.
- cts_n is sampled only in IDLE and on the final STOP cycle. Asserting it (high) mid-frame never truncates the frame.
- busy = (FSM != IDLE) | (fifo_level != 0).

Decomposition:
- Package flexsoc_uart_pkg holds:
  - the uart_tx_state_t enum (IDLE, START, DATA, STOP);
  - the divisor function calc_divisor(clk_hz, baud);
  - the constant UART_DATA_BITS=8.
- One sub-module, sync_fifo:
  - parameters WIDTH and DEPTH;
  - ports wr_en/wr_data, rd_en/rd_data with show-ahead (first-word-fall-through) reads, full, empty, level;
  - synchronous active-high reset.
- The FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan:
- Single byte (CLK_HZ=800, BAUD=100, so DIVISOR=8): write 0xA5 at edge k -> UART_TX falls after edge k+1. Bits sampled mid-bit read 0,1,0,1,0,0,1,0,1 then stop=1. Frame is 80 cycles; busy is low from cycle k+81.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles -> three contiguous 80-cycle frames with no idle cycle between the stop bit and the next start bit. fifo_level reads 1,2,1,0 at the expected edges.
- Full/backpressure (DEPTH=4): hold in_valid high with bytes 0x10..0x15 -> in_ready low once fifo_level=4. All 6 bytes are transmitted in order and none are lost.
- Flow control: set cts_n=1 a few cycles into the frame for 0x3C with 0x3D queued -> 0x3C completes fully, then the line idles high. After cts_n=0, 0x3D starts within 1 cycle.
- Reset mid-frame: assert RESET during data bit 3 -> on the next edge UART_TX=1, fifo_level=0, busy=0, in_ready=0. After release, a new byte 0x81 transmits correctly.
- STOP_BITS=2: send 0xC3 -> stop period is 16 cycles; frame is 88 cycles.
